// File: rtl/vx_tcu_fedp_seq.sv
// Issue/collect sequencer for one fused dot-product (FEDP) unit: chains K operand chunks
// through the fixed-latency pipeline, feeding each D back as the next C.
// Optional performance counters are compiled in with `define TCU_FEDP_SEQ_PERF_EN.
module vx_tcu_fedp_seq #(
    parameter int N       = 4,
    parameter int LATENCY = 16,
    parameter int KW      = 8,
    parameter int XLEN    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_fmt_s,
    input  logic [2:0]          req_fmt_d,
    input  logic [KW-1:0]       req_ksteps,
    input  logic [XLEN-1:0]     req_c_init,
    input  logic                opd_valid,
    output logic                opd_ready,
    input  logic [N*XLEN-1:0]   opd_a,
    input  logic [N*XLEN-1:0]   opd_b,
    output logic                fedp_enable,
    output logic [2:0]          fedp_fmt_s,
    output logic [2:0]          fedp_fmt_d,
    output logic [N*XLEN-1:0]   fedp_a_row,
    output logic [N*XLEN-1:0]   fedp_b_col,
    output logic [XLEN-1:0]     fedp_c_val,
    input  logic [XLEN-1:0]     fedp_d_val,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_d
`ifdef TCU_FEDP_SEQ_PERF_EN
    ,
    input  logic                perf_clear,
    output logic [31:0]         perf_busy,
    output logic [31:0]         perf_opd_stall
`endif
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("vx_tcu_fedp_seq: LATENCY must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [2:0]       fmt_s_r, fmt_s_nxt_s;
    logic [2:0]       fmt_d_r, fmt_d_nxt_s;
    logic [KW-1:0]    k_rem_r, k_rem_nxt_s;
    logic [XLEN-1:0]  acc_r, acc_nxt_s;
    logic [CW-1:0]    wait_cnt_r, wait_cnt_nxt_s;

    // State and datapath register update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fmt_s_r    <= 3'd0;
            fmt_d_r    <= 3'd0;
            k_rem_r    <= {KW{1'b0}};
            acc_r      <= {XLEN{1'b0}};
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fmt_s_r    <= fmt_s_nxt_s;
            fmt_d_r    <= fmt_d_nxt_s;
            k_rem_r    <= k_rem_nxt_s;
            acc_r      <= acc_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt_s    = state_r;
        fmt_s_nxt_s    = fmt_s_r;
        fmt_d_nxt_s    = fmt_d_r;
        k_rem_nxt_s    = k_rem_r;
        acc_nxt_s      = acc_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    fmt_s_nxt_s = req_fmt_s;
                    fmt_d_nxt_s = req_fmt_d;
                    k_rem_nxt_s = req_ksteps;
                    acc_nxt_s   = req_c_init;
                    // A zero-step job answers with c_init and never touches the FEDP
                    if (req_ksteps == {KW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (opd_valid) begin
                    wait_cnt_nxt_s = CW'(LATENCY - 1);
                    k_rem_nxt_s    = k_rem_r - KW'(1);
                    state_nxt_s    = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == {CW{1'b0}}) begin
                    acc_nxt_s = fedp_d_val;
                    if (k_rem_r == {KW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshakes and FEDP controls are decoded straight from registered state
    assign req_ready   = (state_r == ST_IDLE);
    assign opd_ready   = (state_r == ST_ISSUE);
    assign rsp_valid   = (state_r == ST_DONE);
    assign fedp_enable = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign fedp_fmt_s  = fmt_s_r;
    assign fedp_fmt_d  = fmt_d_r;
    assign fedp_c_val  = acc_r;
    assign fedp_a_row  = opd_a;
    assign fedp_b_col  = opd_b;
    assign rsp_d       = acc_r;

`ifdef TCU_FEDP_SEQ_PERF_EN
    logic [31:0] perf_busy_r;
    logic [31:0] perf_opd_stall_r;

    // Saturating busy / operand-stall counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            perf_busy_r      <= 32'd0;
            perf_opd_stall_r <= 32'd0;
        end else begin
            if ((state_r != ST_IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end else begin
                perf_busy_r <= perf_busy_r;
            end
            if ((state_r == ST_ISSUE) && !opd_valid && (perf_opd_stall_r != 32'hFFFF_FFFF)) begin
                perf_opd_stall_r <= perf_opd_stall_r + 32'd1;
            end else begin
                perf_opd_stall_r <= perf_opd_stall_r;
            end
        end
    end

    assign perf_busy      = perf_busy_r;
    assign perf_opd_stall = perf_opd_stall_r;
`endif

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Directed bench for vx_tcu_fedp_seq (N=1) with a behavioural enable-gated FEDP pipeline
// that computes a real-valued dot product of the 16-bit elements plus C.
module tb_vx_tcu_fedp_seq;

    localparam int N   = 1;
    localparam int LAT = 4;
    localparam int KW  = 8;
    localparam int XL  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready;
    logic [2:0]      req_fmt_s, req_fmt_d;
    logic [KW-1:0]   req_ksteps;
    logic [XL-1:0]   req_c_init;
    logic            opd_valid, opd_ready;
    logic [N*XL-1:0] opd_a, opd_b;
    logic            fedp_enable;
    logic [2:0]      fedp_fmt_s, fedp_fmt_d;
    logic [N*XL-1:0] fedp_a_row, fedp_b_col;
    logic [XL-1:0]   fedp_c_val, fedp_d_val;
    logic            rsp_valid, rsp_ready;
    logic [XL-1:0]   rsp_d;

    int errors = 0;
    int checks = 0;

    logic [31:0] c_seen [8];
    logic [2:0]  fs_seen [8];
    logic [2:0]  fd_seen [8];
    int          n_hs, hs_cyc, rdy_cnt;
    int          lat;
    logic [31:0] d;

    always #5 clk = ~clk;

`ifdef TCU_FEDP_SEQ_PERF_EN
    logic        perf_clear = 1'b0;
    logic [31:0] perf_busy, perf_opd_stall;
`endif

    vx_tcu_fedp_seq #(.N(N), .LATENCY(LAT), .KW(KW), .XLEN(XL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
        .req_ksteps(req_ksteps), .req_c_init(req_c_init),
        .opd_valid(opd_valid), .opd_ready(opd_ready),
        .opd_a(opd_a), .opd_b(opd_b),
        .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
        .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
        .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d)
`ifdef TCU_FEDP_SEQ_PERF_EN
        , .perf_clear(perf_clear), .perf_busy(perf_busy), .perf_opd_stall(perf_opd_stall)
`endif
    );

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [2:0] fmt, input logic [15:0] h);
        real v;
        if (fmt == 3'd5)
            v = (h[14:7] == 8'd0) ? 0.0 : (1.0 + real'(h[6:0]) / 128.0) * pow2(int'(h[14:7]) - 127);
        else
            v = (h[14:10] == 5'd0) ? real'(h[9:0]) * pow2(-24)
                                   : (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real v;
        v = (f[30:23] == 8'd0) ? 0.0 : (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] b;
        b = $realtobits(v);
        if (v == 0.0) return 32'd0;
        return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    endfunction

    function automatic logic [31:0] fedp_ref(input logic [2:0] fmt, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        return r2f(h2r(fmt, a[15:0]) * h2r(fmt, b[15:0]) +
                   h2r(fmt, a[31:16]) * h2r(fmt, b[31:16]) + f2r(c));
    endfunction

    // Behavioural FEDP: LAT-stage pipeline advancing only while enabled
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (fedp_enable) begin
            pipe[0] <= fedp_ref(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fedp_d_val = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One job: req at cycle 0, operands fed on request, optional stall/hold/abort
    task automatic run_job(input logic [2:0] fs, input logic [2:0] fd, input logic [7:0] k,
                           input logic [31:0] c, input logic [31:0] ab, input int stall,
                           input int hold, input int abort, output int lat_o,
                           output logic [31:0] d_o);
        int  cyc, stall_left, held;
        bit  done;
        @(negedge clk);
        req_valid = 1'b1; req_fmt_s = fs; req_fmt_d = fd; req_ksteps = k; req_c_init = c;
        cyc = 0; n_hs = 0; rdy_cnt = 0; held = 0; done = 1'b0; stall_left = stall;
        lat_o = -1; d_o = 32'd0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; opd_valid = 1'b0; rsp_ready = 1'b0;
            if (abort != 0 && n_hs == abort) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_req_ready", 32'(req_ready), 32'd1);
                chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("abort_fedp_en", 32'(fedp_enable), 32'd0);
                done = 1'b1;
            end else if (opd_ready) begin
                rdy_cnt++;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    opd_valid = 1'b1; opd_a = ab; opd_b = ab;
                    chk("issue_fedp_en", 32'(fedp_enable), 32'd1);
                    c_seen[n_hs] = fedp_c_val; fs_seen[n_hs] = fedp_fmt_s; fd_seen[n_hs] = fedp_fmt_d;
                    hs_cyc = cyc;
                    n_hs++;
                end
            end else if (rsp_valid) begin
                if (lat_o < 0) begin
                    lat_o = cyc; d_o = rsp_d;
                end
                if (held < hold) begin
                    chk("hold_rsp_d", rsp_d, d_o);
                    chk("hold_req_ready", 32'(req_ready), 32'd0);
                    held++;
                end else begin
                    rsp_ready = 1'b1;
                    done = 1'b1;
                end
            end
        end
        chk("job_completed", 32'(done), 32'd1);
        if (abort == 0) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("idle_after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_fmt_s = 3'd0; req_fmt_d = 3'd0;
        req_ksteps = 8'd0; req_c_init = 32'd0; opd_valid = 1'b0; opd_a = 32'd0;
        opd_b = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_opd_ready", 32'(opd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fedp_en", 32'(fedp_enable), 32'd0);
        chk("rst_rsp_d", rsp_d, 32'd0);
        chk("rst_c_val", fedp_c_val, 32'd0);
        chk("rst_fmts", {26'd0, fedp_fmt_s, fedp_fmt_d}, 32'd0);

        // fp16 single step: 1*1 + 1*1 + 0 = 2.0
        run_job(3'd1, 3'd0, 8'd1, 32'h0000_0000, 32'h3C00_3C00, 0, 0, 0, lat, d);
        chk("k1_rsp_d", d, 32'h4000_0000);
        chk("k1_job_latency", 32'(lat), 32'(LAT + 2));
        chk("k1_opd_to_rsp", 32'(lat - hs_cyc), 32'(LAT + 1));

        // fp16 three steps from 1.0: C = 1, 3, 5 -> 7.0
        run_job(3'd1, 3'd2, 8'd3, 32'h3F80_0000, 32'h3C00_3C00, 0, 0, 0, lat, d);
        chk("k3_c0", c_seen[0], 32'h3F80_0000);
        chk("k3_c1", c_seen[1], 32'h4040_0000);
        chk("k3_c2", c_seen[2], 32'h40A0_0000);
        chk("k3_rsp_d", d, 32'h40E0_0000);
        chk("k3_job_latency", 32'(lat), 32'(3 * (LAT + 1) + 1));
        chk("k3_fmt_d", 32'(fd_seen[2]), 32'd2);

        // bf16 two steps: 2.0 per step -> 4.0
        run_job(3'd5, 3'd3, 8'd2, 32'h0000_0000, 32'h3F80_3F80, 0, 0, 0, lat, d);
        chk("bf16_fmt_s0", 32'(fs_seen[0]), 32'd5);
        chk("bf16_fmt_s1", 32'(fs_seen[1]), 32'd5);
        chk("bf16_fmt_d", 32'(fd_seen[1]), 32'd3);
        chk("bf16_rsp_d", d, 32'h4080_0000);

        // zero steps: c_init returned next cycle, no operand ready
        run_job(3'd1, 3'd0, 8'd0, 32'h1234_5678, 32'h3C00_3C00, 0, 0, 0, lat, d);
        chk("k0_rsp_d", d, 32'h1234_5678);
        chk("k0_latency", 32'(lat), 32'd1);
        chk("k0_opd_ready_cycles", 32'(rdy_cnt), 32'd0);

        // operand stall of 5 cycles, then response held off 4 cycles
        run_job(3'd1, 3'd0, 8'd1, 32'h0000_0000, 32'h3C00_3C00, 5, 4, 0, lat, d);
        chk("bp_rsp_d", d, 32'h4000_0000);
        chk("bp_opd_ready_cycles", 32'(rdy_cnt), 32'd6);
        chk("bp_handshakes", 32'(n_hs), 32'd1);
        chk("bp_opd_to_rsp", 32'(lat - hs_cyc), 32'(LAT + 1));

        // reset during WAIT of step 2 of 3, then a fresh job
        run_job(3'd1, 3'd0, 8'd3, 32'h3F80_0000, 32'h3C00_3C00, 0, 0, 2, lat, d);
        chk("abort_no_rsp", 32'(lat), 32'hFFFF_FFFF);
        run_job(3'd1, 3'd0, 8'd1, 32'h0000_0000, 32'h3C00_3C00, 0, 0, 0, lat, d);
        chk("post_abort_rsp_d", d, 32'h4000_0000);
        chk("post_abort_latency", 32'(lat), 32'(LAT + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
